// File: rtl/mem_bus_arbiter_if.sv
// Bundled requester, bus and response signals of mem_bus_arbiter.
// slave = arbiter side, master = requesters plus memory-bus side.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          bus_req_read;
  logic                          bus_req_write;
  logic [ID_WIDTH-1:0]           bus_req_id;
  logic [ADDR_WIDTH-1:0]         bus_req_addr;
  logic [DATA_WIDTH-1:0]         bus_req_data;
  logic                          bus_req_ready;

  logic                          bus_rsp_valid;
  logic [ID_WIDTH-1:0]           bus_rsp_id;
  logic [ADDR_WIDTH-1:0]         bus_rsp_addr;
  logic [DATA_WIDTH-1:0]         bus_rsp_data;

  logic [NUM_REQ-1:0]            rsp_valid;
  logic [ADDR_WIDTH-1:0]         rsp_addr;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          err_orphan;

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    input  bus_req_ready,
    input  bus_rsp_valid, bus_rsp_id, bus_rsp_addr, bus_rsp_data,
    output req_ready,
    output bus_req_read, bus_req_write, bus_req_id, bus_req_addr, bus_req_data,
    output rsp_valid, rsp_addr, rsp_data, err_orphan
  );

  modport master (
    output req_valid, req_write, req_addr, req_data,
    output bus_req_ready,
    output bus_rsp_valid, bus_rsp_id, bus_rsp_addr, bus_rsp_data,
    input  req_ready,
    input  bus_req_read, bus_req_write, bus_req_id, bus_req_addr, bus_req_data,
    input  rsp_valid, rsp_addr, rsp_data, err_orphan
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory-bus request port between NUM_REQ requesters and routes read responses back by id.
// Define MEM_BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.slave  mb
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0]         outst [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic                  slot_free;
  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [NUM_REQ-1:0]    gnt_onehot;
  logic                  accept;
  logic [NUM_REQ-1:0]    cnt_inc;
  logic [NUM_REQ-1:0]    cnt_dec;
  logic [NUM_REQ-1:0]    rsp_hit;
  logic                  orphan;

  logic                  slot_read;
  logic                  slot_write;
  logic [ID_WIDTH-1:0]   slot_id;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic [DATA_WIDTH-1:0] slot_data;
  logic                  err_q;

`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
  logic [ID_WIDTH-1:0]   rr_ptr;
`endif

  // The outstanding limit only throttles reads; writes are never counted.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = mb.req_valid[i] & (mb.req_write[i] | (outst[i] < CW'(MAX_OUTST)));
    end
  end

  // A busy slot frees up in the same cycle the bus takes it.
  assign slot_free = ~(slot_read | slot_write) | mb.bus_req_ready;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_BUS_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (gnt_found && slot_free) gnt_onehot[gnt_idx] = 1'b1;
  end

  assign mb.req_ready = gnt_onehot;
  assign accept       = |gnt_onehot;

  // Response routing: only ids naming a requester with reads in flight are delivered.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hit[i] = mb.bus_rsp_valid && (mb.bus_rsp_id == ID_WIDTH'(i)) && (outst[i] != '0);
      cnt_inc[i] = gnt_onehot[i] & ~mb.req_write[i];
    end
  end

  assign cnt_dec      = rsp_hit;
  assign orphan       = mb.bus_rsp_valid & ~(|rsp_hit);
  assign mb.rsp_valid = rsp_hit;
  assign mb.rsp_addr  = mb.bus_rsp_addr;
  assign mb.rsp_data  = mb.bus_rsp_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_read  <= 1'b0;
      slot_write <= 1'b0;
      slot_id    <= '0;
      slot_addr  <= '0;
      slot_data  <= '0;
      err_q      <= 1'b0;
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
      for (int i = 0; i < NUM_REQ; i++) outst[i] <= '0;
    end else begin
      if (accept) begin
        slot_read  <= ~mb.req_write[gnt_idx];
        slot_write <= mb.req_write[gnt_idx];
        slot_id    <= gnt_idx;
        slot_addr  <= mb.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        slot_data  <= mb.req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
`ifndef MEM_BUS_ARB_FIXED_PRIO_EN
        rr_ptr     <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
`endif
      end else if (mb.bus_req_ready) begin
        // Drained with nothing new: strobes drop, address and data keep their last value.
        slot_read  <= 1'b0;
        slot_write <= 1'b0;
      end

      // A simultaneous accept and response leave the count unchanged.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      outst[i] <= outst[i] + CW'(1);
        else if (cnt_dec[i] && !cnt_inc[i]) outst[i] <= outst[i] - CW'(1);
      end

      if (orphan) err_q <= 1'b1;
    end
  end

  assign mb.bus_req_read  = slot_read;
  assign mb.bus_req_write = slot_write;
  assign mb.bus_req_id    = slot_id;
  assign mb.bus_req_addr  = slot_addr;
  assign mb.bus_req_data  = slot_data;
  assign mb.err_orphan    = err_q;

endmodule
